// File: rtl/butterfly_stage_pipe.sv
// One registered butterfly/Benes stage: strided 2x2 switches, two-deep valid/ready pipe,
// per-beat bypass and a shadow switch config that only takes effect between frames.

module butterfly_switch #(
    parameter int DW = 512
) (
    input  logic          i_sel,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_c,
    output logic [DW-1:0] o_a,
    output logic [DW-1:0] o_c
);
    assign o_a = i_sel ? i_c : i_a;
    assign o_c = i_sel ? i_a : i_c;
endmodule

module butterfly_stage_pipe #(
    parameter int DATA_WIDTH = 512,
    parameter int PORT_NUM   = 32,
    parameter int STRIDE     = 1,
    parameter int SWITCH_NUM = PORT_NUM / 2
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 CFG_WE,
    input  logic [SWITCH_NUM-1:0]                CFG_SET,
    output logic                                 CFG_PENDING,
    input  logic                                 I_VALID,
    output logic                                 I_READY,
    input  logic                                 I_LAST,
    input  logic                                 I_BYPASS,
    input  logic [0:PORT_NUM-1][DATA_WIDTH-1:0]  I_PORT,
    output logic                                 O_VALID,
    input  logic                                 O_READY,
    output logic                                 O_LAST,
    output logic [0:PORT_NUM-1][DATA_WIDTH-1:0]  O_PORT,
    output logic [15:0]                          O_FRAME_CNT
);
    logic                                 r_s1_valid;
    logic                                 r_s1_last;
    logic [SWITCH_NUM-1:0]                r_s1_sel;
    logic [0:PORT_NUM-1][DATA_WIDTH-1:0]  r_s1_data;
    logic                                 r_s2_valid;
    logic                                 r_s2_last;
    logic [0:PORT_NUM-1][DATA_WIDTH-1:0]  r_s2_data;
    logic [SWITCH_NUM-1:0]                r_active;
    logic [SWITCH_NUM-1:0]                r_shadow;
    logic                                 r_pending;
    logic                                 r_in_frame;
    logic [15:0]                          r_frame_cnt;

    logic                                 w_s2_free;
    logic                                 w_in_ready;
    logic                                 w_acc;
    logic                                 w_s1_xfer;
    logic                                 w_commit;
    logic [0:PORT_NUM-1][DATA_WIDTH-1:0]  w_swap;

    assign w_s2_free  = ~r_s2_valid | O_READY;
    assign w_in_ready = ~r_s1_valid | w_s2_free;
    assign w_acc      = I_VALID & w_in_ready;
    assign w_s1_xfer  = r_s1_valid & w_s2_free;
    // Swap config only between frames: at the closing beat, or while idle outside a frame.
    assign w_commit   = r_pending & ((w_acc & I_LAST) | (~r_in_frame & ~w_acc));

    // Switch s pairs port a with a+STRIDE inside its block of 2*STRIDE ports.
    for (genvar s = 0; s < SWITCH_NUM; s++) begin : g_sw
        localparam int A = 2 * (s / STRIDE) * STRIDE + (s % STRIDE);
        localparam int C = A + STRIDE;
        butterfly_switch #(.DW(DATA_WIDTH)) u_sw (
            .i_sel (r_s1_sel[s]),
            .i_a   (r_s1_data[A]),
            .i_c   (r_s1_data[C]),
            .o_a   (w_swap[A]),
            .o_c   (w_swap[C])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sel   <= '0;
            r_s1_data  <= '0;
        end else if (w_acc) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= I_LAST;
            r_s1_sel   <= r_active & {SWITCH_NUM{~I_BYPASS}};
            r_s1_data  <= I_PORT;
        end else if (w_s1_xfer) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_s1_xfer) begin
            r_s2_valid <= 1'b1;
            r_s2_last  <= r_s1_last;
            r_s2_data  <= w_swap;
        end else if (O_READY) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_active   <= '0;
            r_shadow   <= '0;
            r_pending  <= 1'b0;
            r_in_frame <= 1'b0;
        end else begin
            if (w_commit)
                r_active <= r_shadow;
            // A write racing a commit lands in the shadow after the old value was promoted.
            if (CFG_WE) begin
                r_shadow  <= CFG_SET;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            if (w_acc)
                r_in_frame <= ~I_LAST;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            r_frame_cnt <= '0;
        else if (r_s2_valid & O_READY & r_s2_last)
            r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign I_READY     = w_in_ready;
    assign O_VALID     = r_s2_valid;
    assign O_LAST      = r_s2_last;
    assign O_PORT      = r_s2_data;
    assign O_FRAME_CNT = r_frame_cnt;
    assign CFG_PENDING = r_pending;
endmodule

// File: tb/tb_butterfly_stage_pipe.sv
// Bench for butterfly_stage_pipe (4 ports x 8 bits, stride 2): queue-based reference
// model checked every cycle, plus directed vectors with hand-computed results.

module tb_butterfly_stage_pipe;
    localparam int DW = 8;
    localparam int PN = 4;
    localparam int ST = 2;
    localparam int SW = PN / 2;
    typedef logic [0:PN-1][DW-1:0] port_t;
    typedef struct { port_t d; logic last; int acc; } beat_t;
    typedef struct { port_t d; logic last; } out_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          CFG_WE = 1'b0;
    logic [SW-1:0] CFG_SET = '0;
    logic          CFG_PENDING;
    logic          I_VALID = 1'b0;
    logic          I_READY;
    logic          I_LAST = 1'b0;
    logic          I_BYPASS = 1'b0;
    port_t         I_PORT = '0;
    logic          O_VALID;
    logic          O_READY = 1'b1;
    logic          O_LAST;
    port_t         O_PORT;
    logic [15:0]   O_FRAME_CNT;

    int n_chk = 0;
    int n_fail = 0;

    butterfly_stage_pipe #(.DATA_WIDTH(DW), .PORT_NUM(PN), .STRIDE(ST)) dut (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_SET(CFG_SET), .CFG_PENDING(CFG_PENDING),
        .I_VALID(I_VALID), .I_READY(I_READY), .I_LAST(I_LAST), .I_BYPASS(I_BYPASS),
        .I_PORT(I_PORT), .O_VALID(O_VALID), .O_READY(O_READY), .O_LAST(O_LAST),
        .O_PORT(O_PORT), .O_FRAME_CNT(O_FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference permutation: switch s exchanges ports a and a+ST when its select is set.
    function automatic port_t perm(input port_t d, input logic [SW-1:0] sel);
        port_t r;
        r = d;
        for (int s = 0; s < SW; s++) begin
            int a;
            int c;
            a = 2 * (s / ST) * ST + (s % ST);
            c = a + ST;
            if (sel[s]) begin
                r[a] = d[c];
                r[c] = d[a];
            end
        end
        return r;
    endfunction

    function automatic port_t tag(input logic [7:0] t);
        return {t, t + 8'h1, t + 8'h2, t + 8'h3};
    endfunction

    // Reference model: beats in flight, config shadow/active, frame counter.
    beat_t         q[$];
    out_t          outs[$];
    bit            cap_en = 1'b1;
    int            ecnt = 0;
    logic [SW-1:0] m_act = '0;
    logic [SW-1:0] m_sh = '0;
    logic          m_pend = 1'b0;
    logic          m_inf = 1'b0;
    logic [15:0]   m_fc = '0;
    logic          hold_v = 1'b0;
    port_t         hold_d;
    logic          hold_l;

    always @(negedge CLK) begin : model
        logic exp_ov, exp_rdy, acc, hs, commit;
        exp_rdy = (q.size() < 2) || O_READY;
        exp_ov  = (q.size() > 0) && (ecnt >= q[0].acc + 1);
        chk("i_ready", I_READY, exp_rdy);
        chk("o_valid", O_VALID, exp_ov);
        chk("cfg_pending", CFG_PENDING, m_pend);
        chk("frame_cnt", O_FRAME_CNT, m_fc);
        if (O_VALID && exp_ov) begin
            chk("o_port", O_PORT, q[0].d);
            chk("o_last", O_LAST, q[0].last);
        end
        if (hold_v) begin
            chk("hold_valid", O_VALID, 1);
            chk("hold_port", O_PORT, hold_d);
            chk("hold_last", O_LAST, hold_l);
        end
        hold_v = O_VALID && !O_READY;
        hold_d = O_PORT;
        hold_l = O_LAST;
        if (cap_en && O_VALID && O_READY) outs.push_back('{O_PORT, O_LAST});
        if (RST) begin
            q.delete();
            m_act = '0; m_sh = '0; m_pend = 1'b0; m_inf = 1'b0; m_fc = '0;
            hold_v = 1'b0;
        end else begin
            acc = I_VALID && exp_rdy;
            hs  = exp_ov && O_READY;
            if (hs) begin
                if (q[0].last) m_fc = m_fc + 16'd1;
                q.delete(0);
            end
            if (acc) q.push_back('{perm(I_PORT, m_act & ~{SW{I_BYPASS}}), I_LAST, ecnt + 1});
            commit = m_pend && ((acc && I_LAST) || (!m_inf && !acc));
            if (commit) begin m_act = m_sh; m_pend = 1'b0; end
            if (CFG_WE) begin m_sh = CFG_SET; m_pend = 1'b1; end
            if (acc) m_inf = !I_LAST;
        end
        ecnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int base, sent, hs, n;
        bit rdy_low, acc;
        port_t p0;
        p0 = {8'hA0, 8'hB1, 8'hC2, 8'hD3};

        tick(); tick();
        RST = 1'b0;
        tick();
        chk("ready_after_rst", I_READY, 1);

        // Idle config load commits on the following edge.
        CFG_SET = 2'b01; CFG_WE = 1'b1;
        tick();
        CFG_WE = 1'b0;
        chk("pend_set", CFG_PENDING, 1);
        tick();
        chk("pend_clr", CFG_PENDING, 0);

        I_VALID = 1'b1; I_PORT = p0; I_LAST = 1'b1;
        tick();
        I_VALID = 1'b0;
        chk("lat_s1_only", O_VALID, 0);
        tick();
        chk("lat_out_valid", O_VALID, 1);
        chk("swap01", O_PORT, {8'hC2, 8'hB1, 8'hA0, 8'hD3});

        I_VALID = 1'b1; I_BYPASS = 1'b1;
        tick();
        I_VALID = 1'b0; I_BYPASS = 1'b0;
        tick();
        chk("bypass_valid", O_VALID, 1);
        chk("bypass", O_PORT, {8'hA0, 8'hB1, 8'hC2, 8'hD3});
        tick();

        // Four-beat stream with downstream stalled in cycles 2..4.
        base = outs.size(); sent = 0; hs = 0; rdy_low = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            O_READY = !(c >= 2 && c <= 4);
            I_VALID = (sent < 4);
            I_PORT  = tag(8'h10 + 8'(sent * 4));
            I_LAST  = (sent == 3);
            #1;
            if (!I_READY) rdy_low = 1'b1;
            acc = I_VALID && I_READY;
            if (O_VALID && O_READY) hs++;
            tick();
            if (acc) sent++;
        end
        I_VALID = 1'b0; I_LAST = 1'b0; O_READY = 1'b1;
        chk("stall_ready_low", rdy_low, 1);
        chk("stream_sent", sent, 4);
        chk("stream_out_cnt", hs, 4);
        chk("stream_captured", outs.size() - base, 4);
        if (outs.size() >= base + 4) begin
            chk("stream_first", outs[base].d, {8'h12, 8'h11, 8'h10, 8'h13});
            chk("stream_last_d", outs[base+3].d, {8'h1E, 8'h1D, 8'h1C, 8'h1F});
            chk("stream_last_f", outs[base+3].last, 1);
        end

        // Config change in mid-frame under 2'b00.
        CFG_SET = 2'b00; CFG_WE = 1'b1;
        tick();
        CFG_WE = 1'b0;
        tick(); tick();
        base = outs.size();
        I_VALID = 1'b1; I_PORT = tag(8'h50); I_LAST = 1'b0;
        tick();
        I_PORT = tag(8'h60); CFG_SET = 2'b11; CFG_WE = 1'b1;
        tick();
        CFG_WE = 1'b0;
        chk("pend_midframe", CFG_PENDING, 1);
        I_PORT = tag(8'h70); I_LAST = 1'b1;
        tick();
        chk("pend_at_last", CFG_PENDING, 0);
        I_PORT = tag(8'h80);
        tick();
        I_VALID = 1'b0; I_LAST = 1'b0;
        tick(); tick(); tick();
        chk("midframe_captured", outs.size() - base, 4);
        if (outs.size() >= base + 4) begin
            chk("midframe_b2", outs[base+1].d, {8'h60, 8'h61, 8'h62, 8'h63});
            chk("midframe_b3", outs[base+2].d, {8'h70, 8'h71, 8'h72, 8'h73});
            chk("next_frame_swap", outs[base+3].d, {8'h82, 8'h83, 8'h80, 8'h81});
        end

        // Reset with both stages full and a config pending.
        O_READY = 1'b0;
        I_VALID = 1'b1; I_PORT = tag(8'h90); I_LAST = 1'b0; CFG_SET = 2'b10; CFG_WE = 1'b1;
        tick();
        CFG_WE = 1'b0; I_PORT = tag(8'hA0);
        tick();
        I_VALID = 1'b0;
        #1;
        chk("full_ready_low", I_READY, 0);
        chk("full_pending", CFG_PENDING, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_ovalid", O_VALID, 0);
        chk("rst_oport", O_PORT, 0);
        chk("rst_pend", CFG_PENDING, 0);
        O_READY = 1'b1;
        tick(); tick();
        I_VALID = 1'b1; I_PORT = tag(8'hB0); I_LAST = 1'b1;
        tick();
        I_VALID = 1'b0;
        tick();
        chk("post_rst_valid", O_VALID, 1);
        chk("post_rst_unswapped", O_PORT, {8'hB0, 8'hB1, 8'hB2, 8'hB3});
        tick();

        // 65537 single-beat frames: counter wraps and lands on 1.
        RST = 1'b1;
        tick();
        RST = 1'b0; cap_en = 1'b0;
        I_VALID = 1'b1; I_LAST = 1'b1;
        n = 0;
        for (int k = 0; k < 70000 && n < 65537; k++) begin
            I_PORT = tag(8'(n));
            #1;
            acc = I_READY;
            tick();
            if (acc) n++;
        end
        I_VALID = 1'b0; I_LAST = 1'b0;
        tick(); tick(); tick();
        chk("wrap_sent", n, 65537);
        chk("frame_wrap", O_FRAME_CNT, 16'd1);
        chk("no_lost_beats", q.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
